// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: default widths and the
// owner encoding used for the last_owner and rd_owner state.
package dmem_arb_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;

  typedef enum logic {
    OWN_P = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/dmem_arbiter_pick.sv
// arb_pick2: two-way winner selection for the dmem arbiter.
// Build option DMEM_ARB_RR_EN: when defined, contention is resolved
// round-robin (the requester that did not win last time); otherwise P has
// fixed priority over D.
import dmem_arb_pkg::*;

module arb_pick2 (
  input  logic       p_req,
  input  logic       d_req,
  input  owner_t     last_owner,
  output logic [1:0] gnt          // bit 0 = P, bit 1 = D, one-hot or zero
);

`ifndef DMEM_ARB_RR_EN
  // Fixed priority never looks at history.
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
`endif

  // Pick at most one winner from the current requests.
  always_comb begin
    gnt = 2'b00;
    if (p_req && d_req) begin
`ifdef DMEM_ARB_RR_EN
      gnt = (last_owner == OWN_D) ? 2'b01 : 2'b10;
`else
      gnt = 2'b01;
`endif
    end else if (p_req) begin
      gnt = 2'b01;
    end else if (d_req) begin
      gnt = 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the processor
// (P) and a DMA/debug loader (D). Grants are combinational and an access
// completes in its grant cycle; read data returns one cycle later.
// Build option DMEM_ARB_RR_EN selects round-robin contention (default:
// fixed priority to P); it is applied inside arb_pick2.
import dmem_arb_pkg::*;

module dmem_arbiter #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,        // asynchronous, active-low
  input  logic              p_req,
  input  logic              p_wren,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_gnt,
  output logic              p_rvalid,
  output logic [DATA_W-1:0] p_rdata,
  input  logic              d_req,
  input  logic              d_wren,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] address_dmem,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  input  logic [DATA_W-1:0] q_dmem
);

  owner_t            last_owner;
  logic              rd_pend;
  owner_t            rd_owner;
  logic [1:0]        pick;
  logic              gnt_any;
  logic              win_wren;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] p_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  arb_pick2 u_pick (
    .p_req      (p_req),
    .d_req      (d_req),
    .last_owner (last_owner),
    .gnt        (pick)
  );

  // Grants are suppressed outright while reset is held.
  assign p_gnt   = pick[0] & reset;
  assign d_gnt   = pick[1] & reset;
  assign gnt_any = p_gnt | d_gnt;

  assign win_wren  = d_gnt ? d_wren  : p_wren;
  assign win_addr  = d_gnt ? d_addr  : p_addr;
  assign win_wdata = d_gnt ? d_wdata : p_wdata;

  // Memory side: pass the winner through, otherwise keep the last access.
  assign wren         = gnt_any & win_wren;
  assign address_dmem = gnt_any ? win_addr  : addr_q;
  assign data         = gnt_any ? win_wdata : data_q;

  // Remember the last presented address/data so they hold while idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
      data_q <= '0;
    end else if (gnt_any) begin
      addr_q <= win_addr;
      data_q <= win_wdata;
    end
  end

  // Arbitration history and the one-deep outstanding-read tracker.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_owner <= OWN_D;
      rd_pend    <= 1'b0;
      rd_owner   <= OWN_P;
    end else begin
      if (gnt_any) begin
        last_owner <= d_gnt ? OWN_D : OWN_P;
      end
      rd_pend <= gnt_any & ~win_wren;
      if (gnt_any && !win_wren) begin
        rd_owner <= d_gnt ? OWN_D : OWN_P;
      end
    end
  end

  assign p_rvalid = rd_pend && (rd_owner == OWN_P);
  assign d_rvalid = rd_pend && (rd_owner == OWN_D);

  // Capture returned read data so rdata holds between responses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      p_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (p_rvalid) p_rdata_q <= q_dmem;
      if (d_rvalid) d_rdata_q <= q_dmem;
    end
  end

  // Memory data flows straight through in the response cycle.
  assign p_rdata = p_rvalid ? q_dmem : p_rdata_q;
  assign d_rdata = d_rvalid ? q_dmem : d_rdata_q;

endmodule
